// File: rtl/bb_uart_frame_tx_if.sv
// Parallel-side handshake of the bridge UART transmitter: payload word, valid, ready.
// The word is taken on a clock edge where data_en and ready are both high.
interface bb_uart_frame_tx_if #(
  parameter int DATA_WIDTH = 22
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_en;
  logic                  ready;

  modport master (output data_in, output data_en, input ready);
  modport slave  (input data_in, input data_en, output ready);
endinterface

// File: rtl/bb_uart_frame_tx.sv
// Wide-word UART TX: start bit, DATA_WIDTH bits LSB first, stop bit; each bit is CLOCKS_PER_PULSE cycles.
// A frame takes (DATA_WIDTH+2)*CLOCKS_PER_PULSE cycles; ready is high only in IDLE, so words offered while busy are dropped.
module bb_uart_frame_tx #(
  parameter int DATA_WIDTH       = 22,
  parameter int CLOCKS_PER_PULSE = 5208
) (
  input  logic                    clk,
  input  logic                    rstn,
  bb_uart_frame_tx_if.slave       bus,
  output logic                    tx,
  output logic                    tx_done
);

  localparam int CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLOCKS_PER_PULSE - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      clk_cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  ready_q;

  assign bus.ready = ready_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      ready_q <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.data_en) begin
            shreg   <= bus.data_in;
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            ready_q <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // Raise tx_done one edge early so the registered pulse lines up with the last stop cycle.
          if (clk_cnt == CNT_PRE) begin
            tx_done <= 1'b1;
          end
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bb_uart_frame_tx.sv
// Directed bench for three transmitter configurations: request (22b, 4 clk/bit), boundary (8b, 2 clk/bit), response (8b, 5208 clk/bit).
module tb_bb_uart_frame_tx;

  logic clk;
  logic rstn;
  logic tx_a, tx_done_a, tx_b, tx_done_b, tx_c, tx_done_c;

  int errors = 0;
  int checks = 0;

  logic [21:0] q_a[$];
  logic [7:0]  q_c[$];

  bb_uart_frame_tx_if #(.DATA_WIDTH(22)) bus_a ();
  bb_uart_frame_tx_if #(.DATA_WIDTH(8))  bus_b ();
  bb_uart_frame_tx_if #(.DATA_WIDTH(8))  bus_c ();

  bb_uart_frame_tx #(.DATA_WIDTH(22), .CLOCKS_PER_PULSE(4)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a), .tx(tx_a), .tx_done(tx_done_a));
  bb_uart_frame_tx #(.DATA_WIDTH(8), .CLOCKS_PER_PULSE(2)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b), .tx(tx_b), .tx_done(tx_done_b));
  bb_uart_frame_tx #(.DATA_WIDTH(8), .CLOCKS_PER_PULSE(5208)) dut_c (
    .clk(clk), .rstn(rstn), .bus(bus_c), .tx(tx_c), .tx_done(tx_done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle n of a request frame (n=1 is the cycle after acceptance): start 1-4, data 5-92, stop 93-96.
  task automatic check_frame_a(input logic [21:0] w);
    logic exp_tx;
    for (int n = 1; n <= 96; n++) begin
      @(negedge clk);
      if (n <= 4)       exp_tx = 1'b0;
      else if (n <= 92) exp_tx = w[(n - 5) / 4];
      else              exp_tx = 1'b1;
      chk("a_tx", 32'(tx_a), 32'(exp_tx));
      chk("a_done", 32'(tx_done_a), 32'(n == 96));
      chk("a_ready", 32'(bus_a.ready), 32'd0);
    end
  endtask

  task automatic check_idle_a(input string tag);
    @(negedge clk);
    chk({tag, "_tx"}, 32'(tx_a), 32'd1);
    chk({tag, "_ready"}, 32'(bus_a.ready), 32'd1);
    chk({tag, "_done"}, 32'(tx_done_a), 32'd0);
  endtask

  // Loopback receiver on the request line: samples mid-bit and checks against the scoreboard.
  initial begin : rx_a
    logic [21:0] w;
    logic        ab;
    logic        stop_bit;
    logic [21:0] e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx_a === 1'b0) begin
        ab = 1'b0;
        w = '0;
        stop_bit = 1'b0;
        @(negedge clk);
        if (!rstn) ab = 1'b1;
        for (int i = 0; i < 23; i++) begin
          repeat (4) begin
            @(negedge clk);
            if (!rstn) ab = 1'b1;
          end
          if (i < 22) w[i] = tx_a;
          else        stop_bit = tx_a;
        end
        if (!ab) begin
          chk("a_rx_expected_frame", 32'(q_a.size() != 0), 32'd1);
          if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a_rx_word", 32'(w), 32'(e));
            chk("a_rx_stop", 32'(stop_bit), 32'd1);
          end
        end
      end
    end
  end

  initial begin : main
    logic [7:0] wc;
    logic [7:0] ec;
    logic       exp_b;
    int         done_at;
    int         done_cnt;
    int         k;

    rstn = 1'b0;
    bus_a.data_en = 1'b0; bus_a.data_in = '0;
    bus_b.data_en = 1'b0; bus_b.data_in = '0;
    bus_c.data_en = 1'b0; bus_c.data_in = '0;

    #12;
    chk("rst_a_tx", 32'(tx_a), 32'd1);
    chk("rst_a_ready", 32'(bus_a.ready), 32'd1);
    chk("rst_a_done", 32'(tx_done_a), 32'd0);
    chk("rst_b_tx", 32'(tx_b), 32'd1);
    chk("rst_b_ready", 32'(bus_b.ready), 32'd1);
    chk("rst_c_tx", 32'(tx_c), 32'd1);
    chk("rst_c_ready", 32'(bus_c.ready), 32'd1);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single request frame
    bus_a.data_in = 22'h2A5A5C; bus_a.data_en = 1'b1; q_a.push_back(22'h2A5A5C);
    @(posedge clk); #1 bus_a.data_en = 1'b0;
    check_frame_a(22'h2A5A5C);
    check_idle_a("single_c97");

    // Back-to-back: data_en held high across the frame boundary
    @(posedge clk); #1;
    bus_a.data_in = 22'h000001; bus_a.data_en = 1'b1;
    q_a.push_back(22'h000001); q_a.push_back(22'h3FFFFF);
    @(posedge clk); #1 bus_a.data_in = 22'h3FFFFF;
    check_frame_a(22'h000001);
    check_idle_a("b2b_gap");
    @(posedge clk); #1 bus_a.data_en = 1'b0;
    check_frame_a(22'h3FFFFF);
    check_idle_a("b2b_end");

    // Busy rejection: a word offered mid-frame is dropped
    @(posedge clk); #1;
    bus_a.data_in = 22'h1C3A96; bus_a.data_en = 1'b1; q_a.push_back(22'h1C3A96);
    @(posedge clk); #1 bus_a.data_en = 1'b0;
    fork
      check_frame_a(22'h1C3A96);
      begin
        repeat (40) @(posedge clk);
        #1 bus_a.data_in = 22'h155555; bus_a.data_en = 1'b1;
        @(posedge clk); #1 bus_a.data_en = 1'b0;
      end
    join
    for (int n = 0; n < 20; n++) check_idle_a("busy_no_extra");

    // Reset in the middle of the data phase
    @(posedge clk); #1;
    bus_a.data_in = 22'h2A5A5C; bus_a.data_en = 1'b1;
    @(posedge clk); #1 bus_a.data_en = 1'b0;
    repeat (26) @(negedge clk);
    chk("rst_mid_pre_tx", 32'(tx_a), 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx_a), 32'd1);
    chk("rst_mid_ready", 32'(bus_a.ready), 32'd1);
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    for (int n = 0; n < 30; n++) check_idle_a("rst_after");
    repeat (60) @(negedge clk);
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);

    // Boundary: 2 clocks per bit, all-ones payload
    @(posedge clk); #1;
    bus_b.data_in = 8'hFF; bus_b.data_en = 1'b1;
    @(posedge clk); #1 bus_b.data_en = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      exp_b = (n > 2);
      chk("b_tx", 32'(tx_b), 32'(exp_b));
      chk("b_done", 32'(tx_done_b), 32'(n == 20));
      chk("b_ready", 32'(bus_b.ready), 32'(n == 21));
    end

    // Response frame at the real bit rate, decoded mid-bit
    @(posedge clk); #1;
    bus_c.data_in = 8'hA5; bus_c.data_en = 1'b1; q_c.push_back(8'hA5);
    @(posedge clk); #1 bus_c.data_en = 1'b0;
    wc = '0; done_at = 0; done_cnt = 0;
    for (int n = 1; n <= 52081; n++) begin
      @(negedge clk);
      if ((n % 5208) == 2604) begin
        k = n / 5208;
        if (k == 0)      chk("c_start", 32'(tx_c), 32'd0);
        else if (k <= 8) wc[k-1] = tx_c;
        else             chk("c_stop", 32'(tx_c), 32'd1);
        if (k == 5)      chk("c_ready_busy", 32'(bus_c.ready), 32'd0);
      end
      if (tx_done_c === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (n == 52081) chk("c_ready_end", 32'(bus_c.ready), 32'd1);
    end
    chk("c_done_cycle", 32'(done_at), 32'd52080);
    chk("c_done_count", 32'(done_cnt), 32'd1);
    ec = q_c.pop_front();
    chk("c_rx_word", 32'(wc), 32'(ec));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bb_uart_frame_tx.md
Name: bb_uart_frame_tx

Overview:
- Wide-word UART transmitter for the bus-bridge serial link.
- It serialises one bridge frame per transaction onto a single TX line, using a ready/valid handshake on the parallel side.
- It is the transmit end paired with the bridge's wide-word UART receiver:
  - request direction: frame = {data, addr, mode}, DATA_WIDTH + BB_ADDR_WIDTH + 1 = 22 bits;
  - response direction: frame = read data, 8 bits.
- One instance drives m_u_tx and another drives s_u_tx inside the bridge; the two are identical except for DATA_WIDTH.

Parameters:
- DATA_WIDTH, 22, number of payload bits per frame (22 for requests, 8 for responses).
- CLOCKS_PER_PULSE, 5208, clock cycles per UART bit; minimum 2.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  payload word; packing is owned by the caller.
- data_en  input  1  valid; word is accepted on a posedge where data_en=1 and ready=1.
- ready  output  1  high only in IDLE; block can accept a word.
- tx  output  1  serial line; idles high.
- tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async, rstn=0) forces:
  - state=IDLE, tx=1, ready=1, tx_done=0;
  - bit counter=0, clock counter=0, shift register=0.
  - Applies mid-frame: the line returns high immediately; the partial frame is abandoned and not resumed.
- Frame format: 1 start bit (0), DATA_WIDTH payload bits LSB first, 1 stop bit (1). No parity. Each bit is held for exactly CLOCKS_PER_PULSE cycles.
- Total frame time is (DATA_WIDTH+2)*CLOCKS_PER_PULSE cycles.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1, ready=1. On data_en=1, capture data_in into the shift register, clear the clock counter, go to START. tx drives 0 from the following cycle.
  - START: tx=0 for CLOCKS_PER_PULSE cycles, then go to DATA with bit index 0.
  - DATA: tx = shift register bit 0. On each bit boundary (clock counter = CLOCKS_PER_PULSE-1), shift right and increment the bit index. After bit index DATA_WIDTH-1 completes, go to STOP.
  - STOP: tx=1 for CLOCKS_PER_PULSE cycles. On the final cycle, tx_done=1 and the next state is IDLE.
- Counters:
  - clock counter width is clog2(CLOCKS_PER_PULSE); it wraps to 0 at CLOCKS_PER_PULSE-1;
  - bit index width is clog2(DATA_WIDTH); no overflow past DATA_WIDTH-1.
- ready is registered: it goes 0 the cycle after acceptance and returns to 1 the cycle after tx_done.
- Back-to-back frames:
  - data_en held high in the first IDLE cycle after STOP starts the next frame;
  - the minimum inter-frame gap is 1 idle-high cycle.
- data_en while ready=0 is ignored. No capture, no queuing; data_in changes during a frame do not affect the frame in flight.
- All outputs are registered; there is no combinational path from data_en/data_in to tx.
- tx is glitch-free: it only changes on bit boundaries and on the start edge.

Test Plan:
- Reset line: assert rstn=0 mid-DATA of a frame with DATA_WIDTH=22, CLOCKS_PER_PULSE=4 -> tx=1, ready=1 immediately. After release, tx stays 1 with no residual bits.
- Single request frame: DATA_WIDTH=22, CLOCKS_PER_PULSE=4, data_in=22'h2A5A5C, one-cycle data_en.
  - tx low for 4 cycles starting 1 cycle after acceptance.
  - First 8 payload bits = 0,0,1,1,1,0,1,0, each held 4 cycles.
  - Stop bit high for 4 cycles; tx_done pulses once at cycle 96 of the frame; ready returns 1 on cycle 97.
- Response frame: DATA_WIDTH=8, CLOCKS_PER_PULSE=5208, data_in=8'hA5 -> receiving bridge UART RX decodes 8'hA5; frame length = 52080 cycles.
- Back-to-back: data_en held high with 22'h000001 then 22'h3FFFFF -> second start bit begins exactly 1 cycle after the first frame's tx_done. A loopback receiver captures both words intact.
- Busy rejection: pulse data_en with 22'h155555 mid-frame -> frame in flight unchanged; no extra frame after tx_done; ready stays 0 until frame end.
- Boundary CLOCKS_PER_PULSE=2, DATA_WIDTH=8, data_in=8'hFF -> start bit 2 cycles low, then 18 cycles high including stop; tx_done at cycle 20.
